// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared types and default constants for the UART transmit arbiter slice.
//   uart_arb_state_t : arbiter FSM state (IDLE, WAIT)
//   F_SIZE_DEF       : default data bits per frame
//   TIMEOUT_CYC_DEF  : default watchdog limit in clk cycles
// Optional feature macro used by the top level: UART_ARB_TIMEOUT_EN
// -----------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } uart_arb_state_t;

    localparam int unsigned F_SIZE_DEF      = 8;
    localparam int unsigned TIMEOUT_CYC_DEF = 2048;

endpackage

// File: rtl/uart_rr_pick.sv
// -----------------------------------------------------------------------------
// uart_rr_pick
// Combinational round-robin search: first set bit of req_valid at or above
// ptr, wrapping modulo N_REQ.
//   req_valid [N_REQ] in  : candidate mask
//   ptr       [IW]    in  : search start index (must be < N_REQ)
//   found             out : some candidate is set
//   idx       [IW]    out : index of the chosen candidate (0 when !found)
// -----------------------------------------------------------------------------
module uart_rr_pick #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned IW    = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req_valid,
    input  logic [IW-1:0]    ptr,
    output logic             found,
    output logic [IW-1:0]    idx
);

    // One extra bit so ptr + k never overflows before the modulo fold.
    logic [IW:0] cand;

    always_comb begin
        found = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            cand = {1'b0, ptr} + (IW+1)'(k);
            if (cand >= (IW+1)'(N_REQ)) begin
                cand = cand - (IW+1)'(N_REQ);
            end
            if (!found && req_valid[cand[IW-1:0]]) begin
                found = 1'b1;
                idx   = cand[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/uart_tx_arb.sv
// -----------------------------------------------------------------------------
// uart_tx_arb
// Round-robin arbiter sharing one UART TX core among N_REQ byte requesters.
// A byte is accepted in IDLE, launched with a one-cycle tx_start, and the
// core is held (WAIT) until tx_end. All outputs are registered.
//   clk, rst           in  : clock, asynchronous active-high reset
//   req_valid [N_REQ]  in  : requester i has a byte pending
//   req_data  [N*F]    in  : requester i byte at [i*F_SIZE +: F_SIZE]
//   req_ready [N_REQ]  out : one-hot one-cycle accept pulse
//   tx_data   [F_SIZE] out : byte to the UART core, stable through WAIT
//   tx_start           out : one-cycle launch pulse
//   tx_end             in  : one-cycle end-of-frame pulse from the core
//   grant_id           out : index of the last/current grant
//   busy               out : high while in WAIT
//   timeout_o          out : one-cycle watchdog pulse
// Optional feature: define UART_ARB_TIMEOUT_EN to enable the WAIT watchdog
// (TIMEOUT_CYC cycles); otherwise timeout_o is tied low.
// -----------------------------------------------------------------------------
module uart_tx_arb
    import uart_pkg::*;
#(
    parameter int unsigned N_REQ       = 4,
    parameter int unsigned F_SIZE      = F_SIZE_DEF,
    parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           req_valid,
    input  logic [N_REQ*F_SIZE-1:0]    req_data,
    output logic [N_REQ-1:0]           req_ready,
    output logic [F_SIZE-1:0]          tx_data,
    output logic                       tx_start,
    input  logic                       tx_end,
    output logic [$clog2(N_REQ)-1:0]   grant_id,
    output logic                       busy,
    output logic                       timeout_o
);

    localparam int unsigned IW = $clog2(N_REQ);

    if (N_REQ < 2 || N_REQ > 8 || TIMEOUT_CYC < 2) begin : g_param_check
        $error("uart_tx_arb: unsupported parameter set");
    end

    uart_arb_state_t   state_q, state_d;
    logic [IW-1:0]     ptr_q, ptr_d;
    logic [N_REQ-1:0]  req_ready_q, req_ready_d;
    logic [F_SIZE-1:0] tx_data_q, tx_data_d;
    logic              tx_start_q, tx_start_d;
    logic [IW-1:0]     grant_id_q, grant_id_d;
    logic              busy_q, busy_d;

    logic              pick_found;
    logic [IW-1:0]     pick_idx;
    logic              tx_end_ok;
    logic              wd_expire;

    uart_rr_pick #(
        .N_REQ (N_REQ),
        .IW    (IW)
    ) u_pick (
        .req_valid (req_valid),
        .ptr       (ptr_q),
        .found     (pick_found),
        .idx       (pick_idx)
    );

    // tx_end arriving alongside our own start pulse belongs to no frame of ours.
    assign tx_end_ok = tx_end & ~tx_start_q;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (pick_found) state_d = WAIT;
            WAIT:    if (tx_end_ok || wd_expire) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output / datapath next values
    always_comb begin
        req_ready_d = '0;
        tx_start_d  = 1'b0;
        tx_data_d   = tx_data_q;
        grant_id_d  = grant_id_q;
        ptr_d       = ptr_q;
        busy_d      = (state_d == WAIT);
        if (state_q == IDLE && pick_found) begin
            req_ready_d = {{(N_REQ-1){1'b0}}, 1'b1} << pick_idx;
            tx_start_d  = 1'b1;
            tx_data_d   = req_data[pick_idx*F_SIZE +: F_SIZE];
            grant_id_d  = pick_idx;
            ptr_d       = (pick_idx == IW'(N_REQ-1)) ? '0 : pick_idx + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q       <= '0;
            req_ready_q <= '0;
            tx_data_q   <= '0;
            tx_start_q  <= 1'b0;
            grant_id_q  <= '0;
            busy_q      <= 1'b0;
        end else begin
            ptr_q       <= ptr_d;
            req_ready_q <= req_ready_d;
            tx_data_q   <= tx_data_d;
            tx_start_q  <= tx_start_d;
            grant_id_q  <= grant_id_d;
            busy_q      <= busy_d;
        end
    end

    assign req_ready = req_ready_q;
    assign tx_data   = tx_data_q;
    assign tx_start  = tx_start_q;
    assign grant_id  = grant_id_q;
    assign busy      = busy_q;

`ifdef UART_ARB_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT_CYC);

    logic [CW-1:0] wd_cnt_q, wd_cnt_d;
    logic          timeout_q;

    // Held at 0 in IDLE, so the tx_start cycle (first WAIT cycle) reads 0.
    always_comb begin
        wd_cnt_d = (state_q == WAIT) ? wd_cnt_q + 1'b1 : '0;
    end

    // A real tx_end in the expiry cycle takes priority over the watchdog.
    assign wd_expire = (state_q == WAIT) && (wd_cnt_q == CW'(TIMEOUT_CYC-1)) && !tx_end_ok;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_cnt_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            wd_cnt_q  <= wd_cnt_d;
            timeout_q <= wd_expire;
        end
    end

    assign timeout_o = timeout_q;
`else
    assign wd_expire = 1'b0;
    assign timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arb.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_arb
// Directed and randomized checks of uart_tx_arb against a behavioural
// round-robin model. Inputs are driven and outputs sampled on the falling edge.
// Watchdog steps depend on UART_ARB_TIMEOUT_EN.
// -----------------------------------------------------------------------------
module tb_uart_tx_arb;

    localparam int N  = 4;
    localparam int F  = 8;
    localparam int TO = 16;
`ifdef UART_ARB_TIMEOUT_EN
    localparam int FRAME_LEN = 12;
`else
    localparam int FRAME_LEN = 50;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic [N-1:0]     req_valid;
    logic [N*F-1:0]   req_data;
    logic [N-1:0]     req_ready;
    logic [F-1:0]     tx_data;
    logic             tx_start;
    logic             tx_end;
    logic [1:0]       grant_id;
    logic             busy;
    logic             timeout_o;

    int checks   = 0;
    int failures = 0;
    int m_ptr    = 0;
    int g;

    always #5 clk = ~clk;

    uart_tx_arb #(
        .N_REQ       (N),
        .F_SIZE      (F),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .tx_data   (tx_data),
        .tx_start  (tx_start),
        .tx_end    (tx_end),
        .grant_id  (grant_id),
        .busy      (busy),
        .timeout_o (timeout_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: first pending requester scanning upward from p, wrapping.
    function automatic int model_pick(input logic [N-1:0] v, input int p);
        for (int k = 0; k < N; k++) begin
            if (v[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    // Called at a falling edge in IDLE with req_valid/req_data already driven.
    task automatic expect_grant(input string tag, output int gnt);
        int           e;
        logic [F-1:0] ed;
        e  = model_pick(req_valid, m_ptr);
        ed = '0;
        if (e >= 0) ed = req_data[e*F +: F];
        @(negedge clk);
        if (e < 0) begin
            chk({tag, ".idle_start"}, {31'd0, tx_start}, 32'd0);
            chk({tag, ".idle_ready"}, {28'd0, req_ready}, 32'd0);
            chk({tag, ".idle_busy"},  {31'd0, busy}, 32'd0);
        end else begin
            chk({tag, ".ready"}, {28'd0, req_ready}, 32'd1 << e);
            chk({tag, ".start"}, {31'd0, tx_start}, 32'd1);
            chk({tag, ".data"},  {24'd0, tx_data}, {24'd0, ed});
            chk({tag, ".gid"},   {30'd0, grant_id}, 32'(e));
            chk({tag, ".busy"},  {31'd0, busy}, 32'd1);
            m_ptr = (e + 1) % N;
        end
        gnt = e;
    endtask

    // Called at the falling edge of the tx_start cycle T; tx_end lands at T+len,
    // returns at the falling edge of T+len+1 (IDLE).
    task automatic run_frame(input int len, input string tag);
        for (int k = 1; k < len; k++) begin
            @(negedge clk);
            chk({tag, ".wait_busy"},  {31'd0, busy}, 32'd1);
            chk({tag, ".wait_start"}, {31'd0, tx_start}, 32'd0);
        end
        @(negedge clk);
        tx_end = 1'b1;
        chk({tag, ".end_busy"}, {31'd0, busy}, 32'd1);
        @(negedge clk);
        tx_end = 1'b0;
        chk({tag, ".after_busy"},  {31'd0, busy}, 32'd0);
        chk({tag, ".after_start"}, {31'd0, tx_start}, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: observed=stuck expected=finish");
        $fatal(1);
    end

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_data  = '0;
        tx_end    = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst.ready",   {28'd0, req_ready}, 32'd0);
        chk("rst.data",    {24'd0, tx_data}, 32'd0);
        chk("rst.start",   {31'd0, tx_start}, 32'd0);
        chk("rst.gid",     {30'd0, grant_id}, 32'd0);
        chk("rst.busy",    {31'd0, busy}, 32'd0);
        chk("rst.timeout", {31'd0, timeout_o}, 32'd0);
        rst = 1'b0;

        // Single requester
        req_valid       = 4'b0100;
        req_data        = $urandom;
        req_data[23:16] = 8'hAA;
        expect_grant("single", g);
        chk("single.gid_2",  {30'd0, grant_id}, 32'd2);
        chk("single.data_aa", {24'd0, tx_data}, 32'h0000_00AA);
        req_valid = '0;
        run_frame(FRAME_LEN, "single");

        // tx_end in IDLE has no effect
        tx_end = 1'b1;
        @(negedge clk);
        tx_end = 1'b0;
        chk("idle_end.busy",  {31'd0, busy}, 32'd0);
        chk("idle_end.start", {31'd0, tx_start}, 32'd0);

        // Fair rotation from a fresh pointer; tx_end->next start spacing is E+2
        rst = 1'b1;
        @(negedge clk);
        rst   = 1'b0;
        m_ptr = 0;
        req_valid = 4'b1111;
        for (int f = 0; f < 5; f++) begin
            req_data = $urandom;
            expect_grant("rot", g);
            chk("rot.seq", {30'd0, grant_id}, 32'(f % 4));
            run_frame(FRAME_LEN, "rot");
        end

        // Pointer wrap: grant 2, then 1011 gives 3 then 0
        req_valid = 4'b0100;
        req_data  = $urandom;
        expect_grant("wrap_a", g);
        req_valid = '0;
        run_frame(FRAME_LEN, "wrap_a");
        req_valid = 4'b1011;
        req_data  = $urandom;
        expect_grant("wrap_b", g);
        chk("wrap.gid_3", {30'd0, grant_id}, 32'd3);
        run_frame(FRAME_LEN, "wrap_b");
        req_data = $urandom;
        expect_grant("wrap_c", g);
        chk("wrap.gid_0", {30'd0, grant_id}, 32'd0);

        // tx_end coincident with tx_start is ignored
        req_valid = '0;
        tx_end    = 1'b1;
        @(negedge clk);
        tx_end = 1'b0;
        chk("coinc.busy",  {31'd0, busy}, 32'd1);
        chk("coinc.start", {31'd0, tx_start}, 32'd0);
        run_frame(5, "coinc");

        // Randomized traffic
        for (int it = 0; it < 40; it++) begin
            req_valid = N'($urandom_range(0, 15));
            req_data  = $urandom;
            expect_grant("rand", g);
            if (g >= 0) begin
                req_valid = N'($urandom);
                req_data  = $urandom;
                run_frame($urandom_range(1, FRAME_LEN), "rand");
            end
        end

        // Reset mid-frame clears everything asynchronously
        req_valid = 4'b0010;
        req_data  = $urandom;
        expect_grant("midrst", g);
        req_valid = '0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst.ready",   {28'd0, req_ready}, 32'd0);
        chk("midrst.data",    {24'd0, tx_data}, 32'd0);
        chk("midrst.start",   {31'd0, tx_start}, 32'd0);
        chk("midrst.gid",     {30'd0, grant_id}, 32'd0);
        chk("midrst.busy",    {31'd0, busy}, 32'd0);
        chk("midrst.timeout", {31'd0, timeout_o}, 32'd0);
        @(negedge clk);
        rst       = 1'b0;
        m_ptr     = 0;
        req_valid = 4'b1111;
        req_data  = $urandom;
        expect_grant("postrst", g);
        chk("postrst.gid_0", {30'd0, grant_id}, 32'd0);
        req_valid = '0;
        run_frame(FRAME_LEN, "postrst");

`ifdef UART_ARB_TIMEOUT_EN
        // Watchdog: no tx_end -> pulse at T+TO
        req_valid = 4'b1000;
        req_data  = $urandom;
        expect_grant("wd", g);
        req_valid = '0;
        for (int k = 1; k < TO; k++) begin
            @(negedge clk);
            chk("wd.pre_timeout", {31'd0, timeout_o}, 32'd0);
            chk("wd.pre_busy",    {31'd0, busy}, 32'd1);
        end
        @(negedge clk);
        chk("wd.timeout", {31'd0, timeout_o}, 32'd1);
        chk("wd.busy",    {31'd0, busy}, 32'd0);
        @(negedge clk);
        chk("wd.pulse_end", {31'd0, timeout_o}, 32'd0);
        chk("wd.idle_busy", {31'd0, busy}, 32'd0);

        // tx_end in the expiry cycle wins over the watchdog
        req_valid = 4'b0001;
        req_data  = $urandom;
        expect_grant("wdtie", g);
        req_valid = '0;
        repeat (TO - 2) @(negedge clk);
        @(negedge clk);
        tx_end = 1'b1;
        @(negedge clk);
        tx_end = 1'b0;
        chk("wdtie.timeout", {31'd0, timeout_o}, 32'd0);
        chk("wdtie.busy",    {31'd0, busy}, 32'd0);
`else
        // No watchdog: WAIT persists without tx_end
        req_valid = 4'b1000;
        req_data  = $urandom;
        expect_grant("nowd", g);
        req_valid = '0;
        for (int k = 0; k < 1000; k++) begin
            @(negedge clk);
            chk("nowd.busy",    {31'd0, busy}, 32'd1);
            chk("nowd.timeout", {31'd0, timeout_o}, 32'd0);
        end
        run_frame(1, "nowd_end");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_tx_arb.md
# uart_tx_arb

Round-robin arbiter that shares one UART transmit FSM among `N_REQ` byte requesters. It accepts one byte at a time from the next eligible requester and launches it into the transmitter with a one-cycle start pulse. It then holds the transmitter until the core reports end-of-frame. It sits between the system-side byte producers and the single UART TX core on the board.

## Interface
- `N_REQ`, 4: number of requesters, 2..8.
- `F_SIZE`, 8: data bits per frame, matches the UART core.
- `TIMEOUT_CYC`, 2048: watchdog limit in clk cycles; used only when the timeout feature is compiled in.

- `clk` in 1: system clock.
- `rst` in 1: asynchronous reset, active-high.
- `req_valid` in `N_REQ`: requester i has a byte pending.
- `req_data` in `N_REQ*F_SIZE`: requester i's byte at `[i*F_SIZE +: F_SIZE]`.
- `req_ready` out `N_REQ`: one-hot, one-cycle accept pulse to the granted requester.
- `tx_data` out `F_SIZE`: byte to the UART core, held stable from `tx_start` until the return to IDLE.
- `tx_start` out 1: one-cycle launch pulse to the UART core.
- `tx_end` in 1: one-cycle end-of-frame pulse from the UART core.
- `grant_id` out `$clog2(N_REQ)`: index of the last or current grant.
- `busy` out 1: high while a frame is owned, i.e. state WAIT.
- `timeout_o` out 1: one-cycle watchdog pulse.

## Operation
- FSM has two states, IDLE and WAIT. All outputs are registered.
- Reset values: state IDLE, rr pointer 0, and `req_ready`, `tx_data`, `tx_start`, `grant_id`, `busy`, `timeout_o` all 0.
- **IDLE:**
  - Pick the first i with `req_valid[i]=1`, searching from pointer `ptr` upward and wrapping mod `N_REQ`.
  - If a requester is found:
    - Register `req_ready<=1<<i`, `tx_start<=1`, `tx_data<=req_data[i]`, `grant_id<=i`.
    - Set `ptr<=(i+1) mod N_REQ` and `state<=WAIT`.
  - If none is found, stay in IDLE with no pulses.
- **Accept and release rules:**
  - A requester has handed off its byte in the cycle `req_ready[i]` is high.
  - It must advance or drop `req_valid` in that same cycle.
  - `req_valid` is not sampled outside IDLE, so a byte is never accepted twice.
- **WAIT:**
  - `req_ready` and `tx_start` return to 0 after their single cycle.
  - On `tx_end=1`, go to IDLE.
  - `tx_end` is ignored in the cycle where `tx_start` is high.
- **Boundary cases:**
  - `tx_end` while in IDLE is ignored.
  - If `tx_end` and the watchdog expiry occur in the same cycle, `tx_end` wins and no `timeout_o` is raised.
  - `rst` mid-frame clears all state and outputs asynchronously. A byte already accepted is lost; there is no retry.
  - Pointer wrap: a grant of `N_REQ-1` sets `ptr` to 0.

## Timing
- Requester valid sampled in IDLE at cycle N → `req_ready` and `tx_start` high in cycle N+1 (latency 1).
- `busy` is high from cycle N+1 through the cycle where `tx_end` is seen. `busy` is 0 in the following cycle.
- `tx_end` in cycle E → IDLE in E+1. The earliest next `tx_start` is E+2.
- Throughput is therefore one frame per (UART frame time + 2) cycles.

## Configuration
- Macro: `UART_ARB_TIMEOUT_EN`.
- **Defined:**
  - A counter of `$clog2(TIMEOUT_CYC)` bits clears to 0 in the `tx_start` cycle and increments every WAIT cycle.
  - At count `TIMEOUT_CYC-1` with no `tx_end`, the next cycle has `timeout_o=1` for one cycle, `busy=0` and state IDLE.
  - Timeline: `tx_start` at T → `timeout_o` at T+`TIMEOUT_CYC`.
- **Undefined:**
  - No counter; WAIT lasts until `tx_end`, indefinitely if it never arrives.
  - `timeout_o` is tied to 0 and the port remains present.

## Structure
- Package `uart_pkg` holds:
  - `uart_arb_state_t`, an enum with IDLE and WAIT;
  - the default `F_SIZE` constant;
  - the default `TIMEOUT_CYC` constant.
- Sub-module `uart_rr_pick` is combinational. Inputs are `req_valid` and `ptr`; outputs are `found` and `idx`. It is reusable by the future RX dispatcher.
- The top level holds the FSM, pointer, output registers and the optional watchdog.

## Test plan
- **Single requester grant:** after reset, `req_valid=4'b0100`, `req_data[23:16]=8'hAA` → next cycle `req_ready=4'b0100`, `tx_start=1`, `tx_data=8'hAA`, `grant_id=2`. `busy=1` until `tx_end` 50 cycles later, then `busy=0`.
- **Fair rotation:** `req_valid=4'b1111` held, `tx_end` returned 50 cycles after each start → `grant_id` sequence 0,1,2,3,0.
- **Pointer wrap:** last grant 2, `req_valid=4'b1011` → grant 3, then grant 0.
- **tx_end timing:** `tx_end` coincident with `tx_start` is ignored and `busy` stays 1. A later `tx_end` at cycle E with `req_valid` pending → next `tx_start` exactly at E+2.
- **Reset mid-frame:** `rst` pulsed during WAIT → all outputs 0 immediately. With `req_valid=4'b1111` after release → first grant is 0.
- **Watchdog:** with `UART_ARB_TIMEOUT_EN`, `TIMEOUT_CYC=16`, no `tx_end` → `timeout_o` pulse at T+16 and `busy=0`. Without the macro, `busy` stays 1 and `timeout_o` stays 0 for 1000 cycles.
